// File: rtl/regfile_sb_8x16_pkg.sv
// Shared definitions for the 8x16 scoreboarded register file.
// Holds the geometry and reset value that every file in this slice uses.
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding).
package regfile_sb_8x16_pkg;

  localparam int RF_WIDTH  = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREG   = 1 << RF_ADDR_W;

  localparam logic [RF_WIDTH-1:0] RF_RESET_VAL = 16'h0000;

endpackage : regfile_sb_8x16_pkg

// File: rtl/regfile_sb_8x16_reg16.sv
// rf_reg16: one WIDTH-bit architectural register with write enable.
// Asynchronous active-high reset to the file-wide reset value.
module rf_reg16
  import regfile_sb_8x16_pkg::*;
#(
  parameter int                WIDTH     = RF_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = RF_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the value; load d when this register is the write-back target.
  // NOTE: the register file is built from resettable flops rather than a RAM
  // macro, so every entry can be cleared asynchronously without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (we) begin
      // NOTE: sequential state uses <= so all flops sample pre-edge values.
      q <= d;
    end
  end

endmodule : rf_reg16

// File: rtl/regfile_sb_8x16.sv
// regfile_sb_8x16: 8-entry x 16-bit register file with a busy scoreboard.
// One write-back and one reservation per cycle, two combinational read
// ports, and a registered protocol-error flag.
// Optional feature macro: RF_BYPASS_EN forwards a same-cycle write-back to
// the read ports (data and busy); without it reads see stored state only.
module regfile_sb_8x16
  import regfile_sb_8x16_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1RegSel,
  input  logic [ADDR_W-1:0] read2RegSel,
  output logic [WIDTH-1:0]  read1Data,
  output logic [WIDTH-1:0]  read2Data,
  output logic              read1Busy,
  output logic              read2Busy,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              resvEn,
  input  logic [ADDR_W-1:0] resvRegSel,
  output logic              err
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]  wr_dec;
  logic [NREG-1:0]  resv_dec;
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic             err_d;
  logic             err_q;
  logic [WIDTH-1:0] regs [NREG];

  // 3:8 decodes of the write-back and reservation targets.
  always_comb begin
    // NOTE: defaults first so no path leaves a bit unassigned (no latch).
    wr_dec   = '0;
    resv_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_dec[i]   = writeEn && (writeRegSel == ADDR_W'(i));
      resv_dec[i] = resvEn  && (resvRegSel  == ADDR_W'(i));
    end
  end

  // Storage: one enabled register per entry; r0 is an ordinary register.
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    rf_reg16 #(
      .WIDTH     (WIDTH),
      .RESET_VAL (WIDTH'(RF_RESET_VAL))
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .we  (wr_dec[g]),
      .d   (writeData),
      .q   (regs[g])
    );
  end

  // Next scoreboard and error state; a reservation overrides a same-edge
  // write-back to the same register because the new producer is in flight.
  always_comb begin
    busy_d = (busy_q & ~wr_dec) | resv_dec;
    err_d  = (resvEn  && busy_q[resvRegSel] && !wr_dec[resvRegSel]) ||
             (writeEn && !busy_q[writeRegSel]);
  end

  // Scoreboard and error flag registers; reset drops every reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

  // Read selects, with optional forwarding of the current write-back.
  always_comb begin
    read1Data = regs[read1RegSel];
    read2Data = regs[read2RegSel];
    read1Busy = busy_q[read1RegSel];
    read2Busy = busy_q[read2RegSel];
`ifdef RF_BYPASS_EN
    if (wr_dec[read1RegSel]) begin
      read1Data = writeData;
      read1Busy = resv_dec[read1RegSel];
    end
    if (wr_dec[read2RegSel]) begin
      read2Data = writeData;
      read2Busy = resv_dec[read2RegSel];
    end
`endif
  end

endmodule : regfile_sb_8x16

// File: tb/tb_regfile_sb_8x16.sv
// Self-checking bench for regfile_sb_8x16: directed scenarios plus random
// traffic compared against an array-based reference model of the file.
module tb_regfile_sb_8x16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel;
  logic [15:0] read1Data, read2Data;
  logic        read1Busy, read2Busy;
  logic        writeEn;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        resvEn;
  logic [2:0]  resvRegSel;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;
  logic        m_err;

  regfile_sb_8x16 dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .read1Busy   (read1Busy),
    .read2Busy   (read2Busy),
    .writeEn     (writeEn),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .resvEn      (resvEn),
    .resvRegSel  (resvRegSel),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_busy = '0;
    m_err  = 1'b0;
  endtask

  // Expected read data for the current inputs.
  function automatic logic [15:0] exp_data(input logic [2:0] sel);
`ifdef RF_BYPASS_EN
    if (writeEn && writeRegSel == sel) return writeData;
`endif
    return m_reg[sel];
  endfunction

  // Expected read busy for the current inputs.
  function automatic logic exp_busy(input logic [2:0] sel);
`ifdef RF_BYPASS_EN
    if (writeEn && writeRegSel == sel) return resvEn && (resvRegSel == sel);
`endif
    return m_busy[sel];
  endfunction

  // Apply one clock edge to the model using the rules of the register file.
  task automatic model_edge();
    logic e;
    e = 1'b0;
    if (resvEn && m_busy[resvRegSel] && !(writeEn && writeRegSel == resvRegSel)) e = 1'b1;
    if (writeEn && !m_busy[writeRegSel]) e = 1'b1;
    if (writeEn) begin
      m_reg[writeRegSel]  = writeData;
      m_busy[writeRegSel] = 1'b0;
    end
    if (resvEn) m_busy[resvRegSel] = 1'b1;
    m_err = e;
  endtask

  task automatic drive(input logic we, input logic [2:0] ws, input logic [15:0] wd,
                       input logic re, input logic [2:0] rs,
                       input logic [2:0] s1, input logic [2:0] s2);
    writeEn = we; writeRegSel = ws; writeData = wd;
    resvEn = re; resvRegSel = rs;
    read1RegSel = s1; read2RegSel = s2;
  endtask

  // Check reads mid-cycle, take an edge, check err, return on the falling edge.
  task automatic cycle(input string tag);
    #1;
    check({tag, "_d1"}, 32'(read1Data), 32'(exp_data(read1RegSel)));
    check({tag, "_d2"}, 32'(read2Data), 32'(exp_data(read2RegSel)));
    check({tag, "_b1"}, 32'(read1Busy), 32'(exp_busy(read1RegSel)));
    check({tag, "_b2"}, 32'(read2Busy), 32'(exp_busy(read2RegSel)));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_err"}, 32'(err), 32'(m_err));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_err", 32'(err), 32'd0);
    check("reset_d1", 32'(read1Data), 32'h0);
    check("reset_b1", 32'(read1Busy), 32'd0);
    rst = 1'b0;

    // Reserve r3, then write it back.
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3, 3'd0);
    cycle("t2_resv");
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd0);
    #1 check("t2_busy_between", 32'(read1Busy), 32'd1);
    cycle("t2_wr");
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd0);
    #1;
    check("t2_data", 32'(read1Data), 32'hBEEF);
    check("t2_busy", 32'(read1Busy), 32'd0);
    check("t2_err", 32'(err), 32'd0);

    // Reserve r5, then reserve and write r5 on the same edge.
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 3'd0);
    cycle("t3_resv");
    drive(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5, 3'd0);
    cycle("t3_both");
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
    #1;
    check("t3_data", 32'(read1Data), 32'h1234);
    check("t3_busy", 32'(read1Busy), 32'd1);
    check("t3_err", 32'(err), 32'd0);

    // Write-back without a reservation, then a double reserve.
    drive(1'b1, 3'd6, 16'h00AA, 1'b0, 3'd0, 3'd6, 3'd0);
    cycle("t4_wr");
    check("t4_err_set", 32'(err), 32'd1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd2);
    cycle("t4_idle");
    check("t4_err_clear", 32'(err), 32'd0);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd6, 3'd2);
    cycle("t4_resv_a");
    check("t4_err_first", 32'(err), 32'd0);
    cycle("t4_resv_b");
    check("t4_err_waw", 32'(err), 32'd1);

    // Write r7 while read port 2 watches it with a pending reservation.
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd0, 3'd7);
    cycle("t5_resv");
    drive(1'b1, 3'd7, 16'hC0DE, 1'b0, 3'd0, 3'd0, 3'd7);
    #1;
`ifdef RF_BYPASS_EN
    check("t5_same_data", 32'(read2Data), 32'hC0DE);
    check("t5_same_busy", 32'(read2Busy), 32'd0);
`else
    check("t5_same_data", 32'(read2Data), 32'h0000);
    check("t5_same_busy", 32'(read2Busy), 32'd1);
`endif
    cycle("t5_wr");
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd7);
    #1;
    check("t5_next_data", 32'(read2Data), 32'hC0DE);
    check("t5_next_busy", 32'(read2Busy), 32'd0);

    // r0 is an ordinary register seen identically on both ports.
    drive(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0);
    cycle("t6_wr");
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    #1;
    check("t6_d1", 32'(read1Data), 32'hFFFF);
    check("t6_d2", 32'(read2Data), 32'hFFFF);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'(($urandom % 2) == 0), 3'($urandom), 16'($urandom),
            1'(($urandom % 5) < 2), 3'($urandom), 3'($urandom), 3'($urandom));
      cycle("rnd");
    end

    // Asynchronous reset mid-cycle, with no clock edge needed to settle.
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    #2;
    rst = 1'b1;
    model_reset();
    for (int s = 0; s < 8; s++) begin
      read1RegSel = 3'(s);
      read2RegSel = 3'(7 - s);
      #0.5;
      check("t1_d1", 32'(read1Data), 32'h0);
      check("t1_d2", 32'(read2Data), 32'h0);
      check("t1_b1", 32'(read1Busy), 32'd0);
      check("t1_b2", 32'(read2Busy), 32'd0);
      check("t1_err", 32'(err), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Traffic after reset proves no reservation survived.
    for (int n = 0; n < 60; n++) begin
      drive(1'(($urandom % 2) == 0), 3'($urandom), 16'($urandom),
            1'(($urandom % 5) < 2), 3'($urandom), 3'($urandom), 3'($urandom));
      cycle("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_sb_8x16
